// File: rtl/disp_sequencer.sv
// 640x480@60 raster sequencer for the 24-game renderer with a tear-free digit bus.
// Optional cursor blink is compiled in with `define DISP_BLINK_EN.
module disp_sequencer #(
  parameter int unsigned CLK_DIV           = 4,
  parameter int unsigned BLINK_PERIOD_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_idx,
  input  logic [3:0]  wr_val,
  input  logic        commit,
  output logic        commit_pending,
  output logic        frame_start,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [47:0] numbers_concat,
  input  logic [3:0]  cursor_idx
);

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  div_q;
  logic        tick;
  logic [9:0]  sx_nxt, sy_nxt;
  logic        line_end, frame_end, swap_point;
  logic        swap_en;
  logic [47:0] shadow, live;

  assign tick = (div_q == 4'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div_q <= '0;
    else             div_q <= div_q + 4'd1;
  end

  always_comb begin
    sx_nxt     = sx;
    sy_nxt     = sy;
    line_end   = tick && (sx == 10'd799);
    frame_end  = line_end && (sy == 10'd524);
    swap_point = line_end && (sy == 10'd479);
    if (tick)     sx_nxt = line_end ? '0 : sx + 10'd1;
    if (line_end) sy_nxt = (sy == 10'd524) ? '0 : sy + 10'd1;
  end

  // Counters are rewritten every clock from their next-state value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      frame_start <= 1'b0;
    end else begin
      sx          <= sx_nxt;
      sy          <= sy_nxt;
      frame_start <= frame_end;
    end
  end

  assign hsync = !((sx >= 10'd656) && (sx <= 10'd751));
  assign vsync = !((sy >= 10'd490) && (sy <= 10'd491));
  assign de    = (sx < 10'd640) && (sy < 10'd480);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    wr_ready       = 1'b0;
    commit_pending = 1'b0;
    swap_en        = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (commit) state_nxt = PENDING;
      end
      PENDING: begin
        commit_pending = 1'b1;
        if (swap_point) state_nxt = SWAP;
      end
      SWAP: begin
        commit_pending = 1'b1;
        swap_en        = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Indices 12..15 complete the handshake but match no nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      live   <= '0;
    end else begin
      if (wr_valid && wr_ready) begin
        for (int unsigned i = 0; i < 12; i++) begin
          if (wr_idx == 4'(i)) shadow[47 - 4*i -: 4] <= wr_val;
        end
      end
      if (swap_en) live <= shadow;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned FC_W = BLINK_PERIOD_LOG2 + 1;

  logic [FC_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst)              frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + FC_W'(1);
  end

  // Blanking is applied on the output only; live keeps the real digit.
  always_comb begin
    numbers_concat = live;
    for (int unsigned i = 0; i < 12; i++) begin
      if (frame_cnt[FC_W-1] && (cursor_idx == 4'(i))) numbers_concat[47 - 4*i -: 4] = 4'hF;
    end
  end
`else
  logic unused_blink;

  assign numbers_concat = live;
  assign unused_blink   = ^cursor_idx ^ (BLINK_PERIOD_LOG2 == 0);
`endif

endmodule
